// File: rtl/qc_enc_pkg.sv
// Shared types and constants for the QC-LDPC encoder frame sequencer.
// Holds the FSM state encoding and the post-fetch drain length.
package qc_enc_pkg;

    localparam int DATA_W_DEF = 27;
    localparam int CW_W_DEF   = 162;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        FETCH,
        DRAIN,
        HOLD
    } state_t;

    // Cycles from the last rom_en until enc_result can be captured.
    function automatic int drain_len(input int rom_lat, input int enc_lat);
        return rom_lat + enc_lat;
    endfunction

endpackage

// File: rtl/qc_valid_pipe.sv
// Delay line that aligns the encoder valid strobe with ROM read latency.
// Cleared by reset so no stale strobes survive a mid-frame reset.
module qc_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/qc_enc_frame_ctrl.sv
// Frame sequencer: clears the encoder, streams ROM words, captures the result.
// Optional QC_ENC_CTRL_CONT_EN adds a cont input for back-to-back frames.
module qc_enc_frame_ctrl
    import qc_enc_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int CW_W      = CW_W_DEF,
    parameter int NUM_WORDS = 18,
    parameter int ADDR_W    = 5,
    parameter int ROM_LAT   = 1,
    parameter int ENC_LAT   = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
`ifdef QC_ENC_CTRL_CONT_EN
    input  logic              cont,
`endif
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              enc_clr,
    output logic              enc_valid,
    output logic [DATA_W-1:0] enc_data,
    input  logic [CW_W-1:0]   enc_result,
    output logic              res_valid,
    output logic [CW_W-1:0]   res_data,
    input  logic              res_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int DL = drain_len(ROM_LAT, ENC_LAT);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
    localparam logic [2:0] LAST_D = 3'(DL - 1);
`ifdef QC_ENC_CTRL_CONT_EN
    localparam logic [ADDR_W-1:0] NW_A = ADDR_W'(NUM_WORDS);
`endif

    state_t state;
    state_t nstate;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] idx;
    logic [2:0]        dcnt;
    logic              cap;
    logic              hs;
    logic              next_cont;

`ifdef QC_ENC_CTRL_CONT_EN
    assign next_cont = cont;
`else
    assign next_cont = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate  = state;
        rom_en  = 1'b0;
        enc_clr = 1'b0;
        cap     = 1'b0;
        hs      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) nstate = CLR;
            end
            CLR: begin
                enc_clr = 1'b1;
                nstate  = FETCH;
            end
            FETCH: begin
                rom_en = 1'b1;
                if (idx == LAST_IDX) nstate = DRAIN;
            end
            DRAIN: begin
                if (dcnt == LAST_D) begin
                    cap    = 1'b1;
                    nstate = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    hs     = 1'b1;
                    nstate = next_cont ? CLR : IDLE;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q    <= '0;
            idx       <= '0;
            dcnt      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            frame_cnt <= '0;
        end else begin
            if (state == IDLE && start) base_q <= base_addr;
            // Continuous mode streams the next ROM window without a start.
            if (hs && next_cont) begin
`ifdef QC_ENC_CTRL_CONT_EN
                base_q <= base_q + NW_A;
`endif
            end
            idx  <= (state == FETCH) ? idx + 1'b1 : '0;
            dcnt <= (state == DRAIN) ? dcnt + 1'b1 : '0;
            if (cap) begin
                res_valid <= 1'b1;
                res_data  <= enc_result;
            end
            if (hs) begin
                res_valid <= 1'b0;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign rom_addr = rom_en ? base_q + idx : '0;
    assign busy     = (state != IDLE);
    assign enc_data = rom_data;

    qc_valid_pipe #(
        .DEPTH(ROM_LAT)
    ) u_pipe (
        .clk (clk),
        .rst (rst),
        .din (rom_en),
        .dout(enc_valid)
    );

endmodule

// File: tb/tb_qc_enc_frame_ctrl.sv
// Self-checking bench for qc_enc_frame_ctrl against a cycle-table model.
// Two instances: defaults, and ROM_LAT=3 / ENC_LAT=0.
module tb_qc_enc_frame_ctrl;

    localparam int N = 18;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sel;
    logic [4:0]   base_addr;
    logic [26:0]  rom_data;
    logic [161:0] enc_result;
    logic         res_ready;
    logic         cont;

    logic         d1_rom_en, d2_rom_en, d1_enc_clr, d2_enc_clr;
    logic         d1_ev, d2_ev, d1_rv, d2_rv, d1_busy, d2_busy;
    logic [4:0]   d1_addr, d2_addr;
    logic [26:0]  d1_ed, d2_ed;
    logic [161:0] d1_rd, d2_rd;
    logic [15:0]  d1_fc, d2_fc;

    logic         o_rom_en, o_enc_clr, o_ev, o_rv, o_busy;
    logic [4:0]   o_addr;
    logic [26:0]  o_ed;
    logic [161:0] o_rd;
    logic [15:0]  o_fc;

    int n_chk  = 0;
    int n_fail = 0;
    int fc_model [2];

    always #5 clk = ~clk;

    qc_enc_frame_ctrl dut1 (
        .clk(clk), .rst(rst), .start(start & ~sel), .base_addr(base_addr),
`ifdef QC_ENC_CTRL_CONT_EN
        .cont(cont),
`endif
        .rom_en(d1_rom_en), .rom_addr(d1_addr), .rom_data(rom_data),
        .enc_clr(d1_enc_clr), .enc_valid(d1_ev), .enc_data(d1_ed),
        .enc_result(enc_result), .res_valid(d1_rv), .res_data(d1_rd),
        .res_ready(res_ready), .busy(d1_busy), .frame_cnt(d1_fc)
    );

    qc_enc_frame_ctrl #(.ROM_LAT(3), .ENC_LAT(0)) dut2 (
        .clk(clk), .rst(rst), .start(start & sel), .base_addr(base_addr),
`ifdef QC_ENC_CTRL_CONT_EN
        .cont(cont),
`endif
        .rom_en(d2_rom_en), .rom_addr(d2_addr), .rom_data(rom_data),
        .enc_clr(d2_enc_clr), .enc_valid(d2_ev), .enc_data(d2_ed),
        .enc_result(enc_result), .res_valid(d2_rv), .res_data(d2_rd),
        .res_ready(res_ready), .busy(d2_busy), .frame_cnt(d2_fc)
    );

    always_comb begin
        o_rom_en  = sel ? d2_rom_en  : d1_rom_en;
        o_addr    = sel ? d2_addr    : d1_addr;
        o_enc_clr = sel ? d2_enc_clr : d1_enc_clr;
        o_ev      = sel ? d2_ev      : d1_ev;
        o_ed      = sel ? d2_ed      : d1_ed;
        o_rv      = sel ? d2_rv      : d1_rv;
        o_rd      = sel ? d2_rd      : d1_rd;
        o_busy    = sel ? d2_busy    : d1_busy;
        o_fc      = sel ? d2_fc      : d1_fc;
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [161:0] rnd_res();
        return 162'({$urandom, $urandom, $urandom, $urandom, $urandom,
                     $urandom});
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_rom_en"}, d1_rom_en | d2_rom_en, 0);
        chk({tag, "_addr"}, d1_addr | d2_addr, 0);
        chk({tag, "_clr"}, d1_enc_clr | d2_enc_clr, 0);
        chk({tag, "_ev"}, d1_ev | d2_ev, 0);
        chk({tag, "_rv"}, d1_rv | d2_rv, 0);
        chk({tag, "_rd"}, d1_rd | d2_rd, 0);
        chk({tag, "_busy"}, d1_busy | d2_busy, 0);
        chk({tag, "_fc"}, d1_fc | d2_fc, 0);
    endtask

    // Called at a falling edge with the selected instance idle.
    task automatic run_frame(input logic [4:0] b, input int hw,
                             input bit restart, input int stop_at);
        int rl, el, t_rv, ev_cnt, fc;
        logic [161:0] exp_res;
        logic exp_en, exp_ev;
        logic [4:0] exp_addr;
        rl = sel ? 3 : 1;
        el = sel ? 0 : 1;
        t_rv = 2 + N + rl + el;
        fc = fc_model[sel];
        ev_cnt = 0;
        exp_res = '0;
        chk("idle_busy", o_busy, 0);
        base_addr  = b;
        start      = 1'b1;
        res_ready  = 1'($urandom);
        rom_data   = 27'($urandom);
        enc_result = rnd_res();
        for (int t = 1; t <= t_rv + hw + 1; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (t == stop_at) return;
            exp_en   = (t >= 2 && t < 2 + N);
            exp_addr = exp_en ? 5'(int'(b) + t - 2) : 5'd0;
            exp_ev   = (t >= 2 + rl && t < 2 + rl + N);
            chk("rom_en", o_rom_en, exp_en);
            chk("rom_addr", o_addr, exp_addr);
            chk("enc_clr", o_enc_clr, t == 1);
            chk("enc_valid", o_ev, exp_ev);
            chk("enc_data", o_ed, rom_data);
            if (o_ev) ev_cnt++;
            if (t <= t_rv + hw) begin
                chk("busy", o_busy, 1);
                chk("res_valid", o_rv, t >= t_rv);
                chk("frame_cnt", o_fc, 16'(fc));
                if (t >= t_rv) chk("res_data", o_rd, exp_res);
            end else begin
                chk("rv_clear", o_rv, 0);
                chk("busy_end", o_busy, 0);
                chk("fc_inc", o_fc, 16'(fc + 1));
                chk("ev_count", ev_cnt, N);
            end
            if (restart && (t == 5 || t == 15)) begin
                start     = 1'b1;
                base_addr = 5'($urandom);
            end
            rom_data = 27'($urandom);
            enc_result = rnd_res();
            if (t == t_rv - 1) exp_res = enc_result;
            if (t < t_rv) res_ready = 1'($urandom);
            else res_ready = (t == t_rv + hw);
        end
        res_ready = 1'b0;
        fc_model[sel] = fc + 1;
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        sel = 1'b0;
        base_addr = '0;
        rom_data = '0;
        enc_result = '0;
        res_ready = 1'b0;
        cont = 1'b0;
        fc_model[0] = 0;
        fc_model[1] = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        run_frame(5'd0, 0, 1'b0, 0);
        run_frame(5'd25, 0, 1'b0, 0);
        run_frame(5'($urandom), 10, 1'b0, 0);
        run_frame(5'($urandom), int'($urandom_range(0, 3)), 1'b1, 0);

        run_frame(5'($urandom), 0, 1'b0, 10);
        rst = 1'b0;
        #1;
        chk_zero("midrst");
        fc_model[0] = 0;
        fc_model[1] = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_ev", d1_ev | d2_ev, 0);
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_ev", d1_ev | d2_ev, 0);
        end
        run_frame(5'd0, 0, 1'b0, 0);

        sel = 1'b1;
        @(negedge clk);
        run_frame(5'd0, 0, 1'b0, 0);
        run_frame(5'($urandom), 2, 1'b0, 0);

`ifdef QC_ENC_CTRL_CONT_EN
        begin
            int k;
            base_addr = 5'd0;
            cont = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            k = 0;
            while (!o_rv && k < 100) begin
                @(negedge clk);
                k++;
            end
            chk("cont_wait1", o_rv, 1);
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            cont = 1'b0;
            chk("cont_busy", o_busy, 1);
            chk("cont_clr", o_enc_clr, 1);
            chk("cont_fc", o_fc, 16'(fc_model[1] + 1));
            @(negedge clk);
            chk("cont_en", o_rom_en, 1);
            chk("cont_addr", o_addr, 5'd18);
            k = 0;
            while (!o_rv && k < 100) begin
                @(negedge clk);
                k++;
            end
            chk("cont_wait2", o_rv, 1);
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            chk("cont_idle", o_busy, 0);
            chk("cont_fc2", o_fc, 16'(fc_model[1] + 2));
            fc_model[1] = fc_model[1] + 2;
        end
`endif

        sel = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            run_frame(5'($urandom), int'($urandom_range(0, 4)), 1'($urandom), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/qc_enc_frame_ctrl.md
Name: qc_enc_frame_ctrl

Overview:
Frame sequencer for the QC-LDPC encoder datapath. On a start request it clears the encoder and generates NUM_WORDS consecutive message-ROM addresses. It aligns the encoder valid strobe with the ROM read latency, then captures the 162-bit encoder result after the last word. The result is presented on a valid/ready output port. It replaces the free-running address/valid logic at the encoder boundary.

Parameters:
DATA_W, 27, width of one message word fed to the encoder per cycle
CW_W, 162, width of encoder result captured per frame
NUM_WORDS, 18, message words per frame (legal 1..2**ADDR_W)
ADDR_W, 5, ROM address width
ROM_LAT, 1, ROM read latency in cycles (legal 1..4)
ENC_LAT, 1, cycles from last enc_valid until enc_result is final (legal 0..4)
CNT_W, 16, frame counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle frame request
base_addr  in  ADDR_W  first ROM address of frame, sampled when start is accepted
rom_en  out  1  ROM read enable
rom_addr  out  ADDR_W  ROM read address
rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_en
enc_clr  out  1  one-cycle encoder accumulator clear
enc_valid  out  1  encoder data strobe
enc_data  out  DATA_W  encoder input word (rom_data passed through)
enc_result  in  CW_W  encoder accumulated output
res_valid  out  1  result valid
res_data  out  CW_W  captured result
res_ready  in  1  downstream accept
busy  out  1  high in any state other than IDLE
frame_cnt  out  CNT_W  completed (handed-off) frames, wraps

Behaviour:
- Reset values: all outputs 0. State is IDLE, and internal counters and pipes are 0.
- States:
  - IDLE → CLR: when start=1. base_addr is latched into an address register.
  - CLR: enc_clr=1 for exactly 1 cycle. The next state is FETCH.
  - FETCH: rom_en=1 and rom_addr = latched base + word index (modulo 2**ADDR_W). The index runs 0..NUM_WORDS-1, one per cycle. After index NUM_WORDS-1 the next state is DRAIN.
  - DRAIN: wait ROM_LAT+ENC_LAT cycles after the last rom_en. On the final DRAIN cycle, enc_result is registered into res_data and res_valid is set. The next state is HOLD.
  - HOLD: res_valid stays high and res_data stays stable. When res_ready=1, res_valid clears on the next edge, frame_cnt increments, and the state returns to IDLE.
- enc_valid is rom_en delayed by exactly ROM_LAT cycles through a shift register. enc_data = rom_data (combinational).
- Exactly NUM_WORDS enc_valid pulses per frame, contiguous, with no gaps.
- Latency: start accepted at cycle 0. enc_clr at cycle 1. First rom_en at cycle 2. First enc_valid at cycle 2+ROM_LAT. res_valid rises at cycle 2+NUM_WORDS+ROM_LAT+ENC_LAT. With defaults this is cycle 22.
- start while busy=1 is ignored, not queued.
- Address wrap: base_addr+index past 2**ADDR_W-1 wraps to 0.
- res_ready=1 while res_valid=0 has no effect.
- Reset asserted mid-frame returns the block to IDLE immediately. The enc_valid pipe is flushed, so no partial-frame strobes appear after reset release. frame_cnt is cleared.
- frame_cnt wraps from 2**CNT_W-1 to 0.

Optional Feature:
QC_ENC_CTRL_CONT_EN:
- Defined: adds input port cont (1 bit). In HOLD with cont=1, the res_ready handshake goes to CLR instead of IDLE. The next frame uses base_addr + NUM_WORDS (modulo 2**ADDR_W), so the ROM is streamed frame after frame without a new start. busy stays high across frames.
- Undefined: no cont port, and every frame requires a start.

Decomposition:
- Package qc_enc_pkg: state enum (IDLE, CLR, FETCH, DRAIN, HOLD), default DATA_W/CW_W constants, and a function computing the DRAIN length.
- One sub-module: qc_valid_pipe, a parameterised delay line of depth ROM_LAT that produces enc_valid from rom_en and is cleared by reset.

Test Plan:
- Defaults, base_addr=0, start pulse, res_ready=1:
  - rom_addr reads 0..17 on cycles 2..19 and enc_valid is high for cycles 3..20.
  - enc_clr is high on cycle 1 only, and res_valid rises on cycle 22.
  - res_data equals enc_result sampled at cycle 21, and frame_cnt is 1.
- base_addr=25: rom_addr sequence is 25..31, then 0..10 (wrap), with 18 strobes total.
- res_ready held 0 for 10 cycles in HOLD:
  - res_valid and res_data stay stable and busy stays 1.
  - After ready=1 for one cycle, res_valid=0, state is IDLE and frame_cnt is incremented once.
- start re-pulsed at cycles 5 and 15 of a frame: no restart, still exactly 18 enc_valid pulses, and frame_cnt increments by 1.
- rst pulled low at cycle 10 of a frame, then released and start issued:
  - Outputs are 0 during reset.
  - No enc_valid appears before the new frame, and the new frame timing matches the first test.
- ROM_LAT=3, ENC_LAT=0: first enc_valid at cycle 5 and res_valid rises at cycle 23. With QC_ENC_CTRL_CONT_EN and cont=1, the second frame's rom_addr starts at 18.
